// File: rtl/salsa20_pkg.sv
// ============================================================================
// Module      : salsa20_pkg
// Description : Shared types and constants for the Salsa20 keystream XOR path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package salsa20_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef logic [31:0] word_t;
    typedef word_t [WORDS_PER_BLOCK-1:0] block_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/salsa20_out_reg.sv
// ============================================================================
// Module      : salsa20_out_reg
// Description : Single-entry valid/ready register carrying a data word and last.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module salsa20_out_reg
    import salsa20_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  word_t in_data_i,
    input  logic  in_last_i,
    output logic  out_valid_o,
    output word_t out_data_o,
    output logic  out_last_o,
    input  logic  out_ready_i
);

    logic  valid_q;
    word_t data_q;
    logic  last_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            last_q  <= in_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/salsa20_stream_xor.sv
// ============================================================================
// Module      : salsa20_stream_xor
// Description : Fetches Salsa20 keystream blocks and XORs them onto a 32-bit stream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module salsa20_stream_xor
    import salsa20_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  nonce,
    input  logic [63:0]  ctr_init,
    output logic         busy,
    output logic         ks_req,
    output logic [63:0]  ks_nonce,
    output logic [63:0]  ks_ctr,
    input  logic         ks_ack,
    input  logic         ks_valid,
    input  logic [511:0] ks_block,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [31:0]  din_data,
    input  logic         din_last,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [31:0]  dout_data,
    output logic         dout_last,
    output logic         ctr_wrap
);

    state_t            state_q, state_d;
    logic [63:0]       ctr_q, ctr_d;
    logic [63:0]       nonce_q, nonce_d;
    logic              wrap_q, wrap_d;
    block_t            buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              oreg_ready;
    logic              push;

    assign ks_req    = (state_q == FETCH);
    assign ks_ctr    = ctr_q;
    assign ks_nonce  = nonce_q;
    assign busy      = (state_q != IDLE);
    assign ctr_wrap  = wrap_q;
    assign din_ready = (state_q == STREAM) && oreg_ready;
    assign push      = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            nonce_q <= '0;
            wrap_q  <= 1'b0;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            nonce_q <= nonce_d;
            wrap_q  <= wrap_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        nonce_d = nonce_q;
        wrap_d  = wrap_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nonce_d = nonce;
                    ctr_d   = ctr_init;
                    wrap_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Counter advances on the request handshake so it always names the next unused block.
                if (ks_ack) begin
                    ctr_d   = ctr_q + 64'd1;
                    if (&ctr_q) begin
                        wrap_d = 1'b1;
                    end
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ks_valid) begin
                    buf_d   = ks_block;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (push) begin
                    idx_d = idx_q + 1'b1;
                    if (din_last) begin
                        state_d = DRAIN;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (dout_valid && dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    salsa20_out_reg u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (push),
        .in_ready_o  (oreg_ready),
        .in_data_i   (din_data ^ buf_q[idx_q]),
        .in_last_i   (din_last),
        .out_valid_o (dout_valid),
        .out_data_o  (dout_data),
        .out_last_o  (dout_last),
        .out_ready_i (dout_ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_salsa20_stream_xor.sv
// ============================================================================
// Module      : tb_salsa20_stream_xor
// Description : Self-checking bench with a keystream core emulator and stream model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_salsa20_stream_xor;

    logic         clk;
    logic         rst;
    logic         start;
    logic [63:0]  nonce;
    logic [63:0]  ctr_init;
    logic         busy;
    logic         ks_req;
    logic [63:0]  ks_nonce;
    logic [63:0]  ks_ctr;
    logic         ks_ack;
    logic         ks_valid;
    logic [511:0] ks_block;
    logic         din_valid;
    logic         din_ready;
    logic [31:0]  din_data;
    logic         din_last;
    logic         dout_valid;
    logic         dout_ready;
    logic [31:0]  dout_data;
    logic         dout_last;
    logic         ctr_wrap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    salsa20_stream_xor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nonce      (nonce),
        .ctr_init   (ctr_init),
        .busy       (busy),
        .ks_req     (ks_req),
        .ks_nonce   (ks_nonce),
        .ks_ctr     (ks_ctr),
        .ks_ack     (ks_ack),
        .ks_valid   (ks_valid),
        .ks_block   (ks_block),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .din_last   (din_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_last  (dout_last),
        .ctr_wrap   (ctr_wrap)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Keystream core emulator state and the reference record of a stream
    bit           core_en;
    bit           fixed_ks;
    int           core_lat;
    logic [511:0] core_next;
    logic [511:0] blk_q[$];
    logic [63:0]  req_ctr_q[$];
    logic [63:0]  req_nonce_q[$];
    logic [31:0]  din_words[$];
    logic [31:0]  out_data_q[$];
    bit           out_last_q[$];

    int   bp_mode;
    bit   din_gaps;
    int   stall_from;
    bit   prev_hold;
    logic [31:0] prev_data;
    logic prev_last;
    int   din_ptr;
    int   n_words;
    bit   din_acc;
    bit   dout_acc;
    int   last_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // One cycle of environment activity, evaluated at the falling edge.
    task automatic cycle_body();
        bit stalled;
        if (din_acc) din_ptr++;

        ks_valid = 1'b0;
        if (core_lat > 0) begin
            core_lat--;
            if (core_lat == 0) begin
                ks_valid = 1'b1;
                ks_block = core_next;
            end
        end
        ks_ack = 1'b0;
        if (core_en && ks_req && core_lat == 0 && !ks_valid && $urandom_range(0, 1) == 1) begin
            ks_ack = 1'b1;
            req_ctr_q.push_back(ks_ctr);
            req_nonce_q.push_back(ks_nonce);
            for (int i = 0; i < 16; i++)
                core_next[32*i +: 32] = fixed_ks ? (32'hA5A5A500 + 32'(i)) : $urandom;
            blk_q.push_back(core_next);
            core_lat = $urandom_range(1, 4);
        end

        if (bp_mode == 2 && stall_from < 0 && out_data_q.size() == 6) stall_from = cyc;
        stalled = (bp_mode == 2) && (stall_from >= 0) && (cyc >= stall_from) && (cyc < stall_from + 5);
        case (bp_mode)
            1:       dout_ready = ($urandom_range(0, 3) != 0);
            2:       dout_ready = !stalled;
            default: dout_ready = 1'b1;
        endcase

        din_valid = (din_ptr < n_words) && (!din_gaps || $urandom_range(0, 3) != 0);
        din_data  = (din_ptr < n_words) ? din_words[din_ptr] : $urandom;
        din_last  = din_valid && (din_ptr == n_words - 1);

        #1;
        if (prev_hold) begin
            chk("hold_valid", 64'(dout_valid), 64'd1);
            chk("hold_data", 64'(dout_data), 64'(prev_data));
            chk("hold_last", 64'(dout_last), 64'(prev_last));
        end
        if (stalled && dout_valid) chk("stall_din_ready", 64'(din_ready), 64'd0);

        din_acc  = din_valid && din_ready;
        dout_acc = dout_valid && dout_ready;
        if (dout_acc) begin
            out_data_q.push_back(dout_data);
            out_last_q.push_back(dout_last);
        end
        prev_hold = dout_valid && !dout_ready;
        prev_data = dout_data;
        prev_last = dout_last;

        if (din_acc && din_last) last_cyc = cyc;
        if (bp_mode == 0 && last_cyc >= 0) begin
            if (cyc == last_cyc + 1) chk("busy_after_last_t1", 64'(busy), 64'd1);
            if (cyc == last_cyc + 2) chk("busy_after_last_t2", 64'(busy), 64'd0);
        end
    endtask

    task automatic run_stream(input logic [63:0] n_nonce, input logic [63:0] c_init, input int nw,
                              input int bp, input bit gaps, input bit fixed);
        int nblk;
        int guard;
        bit done;
        logic [511:0] blk;
        logic [31:0]  exp_word;
        bit exp_wrap;

        din_words.delete();
        blk_q.delete();
        req_ctr_q.delete();
        req_nonce_q.delete();
        out_data_q.delete();
        out_last_q.delete();
        for (int i = 0; i < nw; i++) din_words.push_back(fixed ? 32'(i) : $urandom);
        n_words = nw; din_ptr = 0; din_acc = 1'b0; bp_mode = bp; din_gaps = gaps;
        stall_from = -1; prev_hold = 1'b0; last_cyc = -1; fixed_ks = fixed;
        core_en = 1'b1; core_lat = 0;

        start = 1'b1; nonce = n_nonce; ctr_init = c_init;
        din_valid = 1'b0; ks_ack = 1'b0; ks_valid = 1'b0; dout_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ks_req", 64'(ks_req), 64'd1);
        chk("start_wrap_clear", 64'(ctr_wrap), 64'd0);

        guard = 0;
        done  = 1'b0;
        while (!done) begin
            cycle_body();
            done = !busy && (out_data_q.size() == nw);
            if (!done) begin
                guard++;
                if (guard > 3000) begin
                    chk("stream_timeout_outcount", 64'(out_data_q.size()), 64'(nw));
                    done = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        din_valid = 1'b0;
        ks_ack = 1'b0;
        ks_valid = 1'b0;

        nblk = (nw + 15) / 16;
        chk("req_count", 64'(req_ctr_q.size()), 64'(nblk));
        for (int b = 0; b < nblk && b < req_ctr_q.size(); b++) begin
            chk("req_ctr", req_ctr_q[b], c_init + 64'(b));
            chk("req_nonce", req_nonce_q[b], n_nonce);
        end
        chk("out_count", 64'(out_data_q.size()), 64'(nw));
        for (int k = 0; k < nw && k < out_data_q.size(); k++) begin
            if (k / 16 < blk_q.size()) begin
                blk = blk_q[k / 16];
                exp_word = din_words[k] ^ blk[32*(k % 16) +: 32];
                chk("dout_data", 64'(out_data_q[k]), 64'(exp_word));
            end
            chk("dout_last", 64'(out_last_q[k]), 64'(k == nw - 1));
        end
        exp_wrap = (c_init + 64'(nblk)) < c_init;
        chk("final_ks_ctr", ks_ctr, c_init + 64'(nblk));
        chk("ctr_wrap", 64'(ctr_wrap), 64'(exp_wrap));
        tick();
    endtask

    initial begin
        logic [63:0] next_ctr;
        rst = 1'b1; start = 1'b0; nonce = '0; ctr_init = '0;
        ks_ack = 1'b0; ks_valid = 1'b0; ks_block = '0;
        din_valid = 1'b0; din_data = '0; din_last = 1'b0; dout_ready = 1'b0;
        core_en = 1'b0; core_lat = 0; din_acc = 1'b0; last_cyc = -1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_ks_req", 64'(ks_req), 64'd0);
        chk("rst_ks_ctr", ks_ctr, 64'd0);
        chk("rst_ks_nonce", ks_nonce, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_din_ready", 64'(din_ready), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout_data", 64'(dout_data), 64'd0);
        chk("rst_dout_last", 64'(dout_last), 64'd0);
        chk("rst_ctr_wrap", 64'(ctr_wrap), 64'd0);
        rst = 1'b0;
        tick();

        run_stream(64'h0001020304050607, 64'd0, 16, 0, 1'b0, 1'b1);
        run_stream($urandom, 64'd5, 20, 0, 1'b1, 1'b0);
        run_stream({$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF, 17, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrap_sticky", 64'(ctr_wrap), 64'd1);
        end
        run_stream({$urandom, $urandom}, 64'd42, 20, 2, 1'b0, 1'b0);
        run_stream({$urandom, $urandom}, 64'd100, 4, 0, 1'b0, 1'b0);
        next_ctr = ks_ctr;
        run_stream({$urandom, $urandom}, next_ctr, 16, 1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            run_stream({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 40), 1, 1'b1, 1'b0);

        // Reset while waiting for keystream, then a stray keystream pulse
        core_en = 1'b0;
        start = 1'b1; nonce = 64'h1111; ctr_init = 64'd9;
        tick();
        start = 1'b0;
        chk("rw_ks_req", 64'(ks_req), 64'd1);
        ks_ack = 1'b1;
        tick();
        ks_ack = 1'b0;
        chk("rw_in_wait_req", 64'(ks_req), 64'd0);
        chk("rw_in_wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ks_valid = 1'b1;
        ks_block = {16{32'hDEADBEEF}};
        din_valid = 1'b1; din_data = 32'h12345678; din_last = 1'b0; dout_ready = 1'b1;
        tick();
        ks_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rw_busy", 64'(busy), 64'd0);
            chk("rw_dout_valid", 64'(dout_valid), 64'd0);
            chk("rw_din_ready", 64'(din_ready), 64'd0);
            chk("rw_ks_req", 64'(ks_req), 64'd0);
            tick();
        end
        chk("rw_ks_ctr", ks_ctr, 64'd0);
        din_valid = 1'b0;
        run_stream({$urandom, $urandom}, 64'd77, 18, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
